// File: rtl/muldiv_pkg.sv
// Shared definitions for the mul/div request arbiter.
//   funct3_e   : RISC-V M-extension funct3 encodings (MUL=0 .. REMU=7)
//   state_e    : arbiter FSM states
//   MDU_OP_W   : width of the one-hot op bus sent to the mul/div unit
//   decode_op  : funct3 -> one-hot op, bit index equal to funct3
package muldiv_pkg;

    localparam int MDU_OP_W = 8;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [MDU_OP_W-1:0] decode_op(input logic [2:0] funct3);
        logic [MDU_OP_W-1:0] onehot;
        onehot = '0;
        onehot[funct3] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/muldiv_rr_arb.sv
// Two-way round-robin grant selection (purely combinational).
//   valid[1:0]  : requester valid bits
//   last_grant  : index of the requester served most recently
//   grant_valid : at least one requester is valid
//   grant_idx   : index of the requester to serve
module muldiv_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |valid;

    always_comb begin
        if (valid == 2'b11) begin
            // Tie: serve whoever was not served last.
            grant_idx = ~last_grant;
        end else begin
            // Sole requester (or none, where the value is unused).
            grant_idx = valid[1];
        end
    end

endmodule

// File: rtl/muldiv_arbiter.sv
// Arbitrates two requesters onto a single shared mul/div unit, one op in
// flight at a time, with a WAIT timeout that returns an error response.
//   clk_i, rst_i                   : clock, async active-high reset
//   req_valid_i/req_ready_o [1:0]  : per-requester handshake
//   req_op_i [5:0]                 : funct3 per requester (3 bits each)
//   req_ra_i/req_rb_i [63:0]       : operands per requester (32 bits each)
//   rsp_valid_o [1:0]              : one-cycle result strobe per requester
//   rsp_result_o, rsp_err_o        : shared result bus and timeout flag
//   mdu_valid_o, mdu_op_o          : issue strobe and one-hot op to the unit
//   mdu_ra_o, mdu_rb_o             : operands to the unit
//   mdu_stall_i                    : unit cannot take an issue this cycle
//   mdu_ready_i, mdu_result_i      : unit result strobe and data
//   busy_o                         : FSM not idle
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    input  logic [5:0]          req_op_i,
    input  logic [63:0]         req_ra_i,
    input  logic [63:0]         req_rb_i,
    output logic [1:0]          req_ready_o,
    output logic [1:0]          rsp_valid_o,
    output logic [31:0]         rsp_result_o,
    output logic                rsp_err_o,
    output logic                mdu_valid_o,
    output logic [MDU_OP_W-1:0] mdu_op_o,
    output logic [31:0]         mdu_ra_o,
    output logic [31:0]         mdu_rb_o,
    input  logic                mdu_stall_i,
    input  logic                mdu_ready_i,
    input  logic [31:0]         mdu_result_i,
    output logic                busy_o
);

    // One extra bit keeps the counter wide enough for TIMEOUT_CYCLES == 1.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]  req_op_w [2];
    logic [31:0] req_ra_w [2];
    logic [31:0] req_rb_w [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req_slice
            assign req_op_w[gi] = req_op_i[3*gi +: 3];
            assign req_ra_w[gi] = req_ra_i[32*gi +: 32];
            assign req_rb_w[gi] = req_rb_i[32*gi +: 32];
        end
    endgenerate

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       ra_q, ra_d;
    logic [31:0]       rb_q, rb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              err_q, err_d;

    logic grant_valid;
    logic grant_idx;

    muldiv_rr_arb u_rr_arb (
        .valid       (req_valid_i),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    grant_d = grant_idx;
                    op_d    = req_op_w[grant_idx];
                    ra_d    = req_ra_w[grant_idx];
                    rb_d    = req_rb_w[grant_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mdu_stall_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ready is tested first so it wins over the terminal count.
                if (mdu_ready_i) begin
                    result_d = mdu_result_i;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
            op_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // Ready is masked while reset is held: the state is already IDLE then,
    // but nothing may be handshaken during reset.
    assign req_ready_o  = (state_q == ST_IDLE && grant_valid && !rst_i)
                          ? {grant_idx, ~grant_idx} : 2'b00;

    assign rsp_valid_o  = (state_q == ST_RESP) ? {grant_q, ~grant_q} : 2'b00;
    assign rsp_result_o = (state_q == ST_RESP) ? result_q : '0;
    assign rsp_err_o    = (state_q == ST_RESP) ? err_q : 1'b0;

    assign mdu_valid_o  = (state_q == ST_ISSUE);
    assign mdu_op_o     = (state_q == ST_ISSUE) ? decode_op(op_q) : '0;
    assign mdu_ra_o     = ra_q;
    assign mdu_rb_o     = rb_q;

    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
module tb_muldiv_arbiter;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [5:0]  req_op_i;
    logic [63:0] req_ra_i, req_rb_i;
    logic [1:0]  req_ready_o, rsp_valid_o;
    logic [31:0] rsp_result_o;
    logic        rsp_err_o, mdu_valid_o;
    logic [7:0]  mdu_op_o;
    logic [31:0] mdu_ra_o, mdu_rb_o;
    logic        mdu_stall_i, mdu_ready_i;
    logic [31:0] mdu_result_i;
    logic        busy_o;

    muldiv_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i),
        .req_ra_i(req_ra_i), .req_rb_i(req_rb_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
        .mdu_valid_o(mdu_valid_o), .mdu_op_o(mdu_op_o),
        .mdu_ra_o(mdu_ra_o), .mdu_rb_o(mdu_rb_o), .mdu_stall_i(mdu_stall_i),
        .mdu_ready_i(mdu_ready_i), .mdu_result_i(mdu_result_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  valid;
        logic [2:0]  op0, op1;
        logic [31:0] ra0, rb0, ra1, rb1;
        int          stall;   // ISSUE cycles with mdu_stall_i high
        int          k;       // WAIT cycle on which ready is given, -1 = never
        logic        grant;
        logic [31:0] res;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [1:0]  valid;
        logic [31:0] result;
        logic        err;
    } rsp_t;

    vec_t tbl [11];
    rsp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural mul/div unit, driven only from what the DUT issued.
    function automatic logic [31:0] mdu_model(input logic [7:0] oh, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0]        u;
        case (oh)
            8'h01: return a * b;
            8'h02: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            8'h04: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            8'h08: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            8'h10: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            8'h20: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            8'h40: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            8'h80: return (b == 0) ? a : a % b;
            default: return 32'hBAD0_BAD0;
        endcase
    endfunction

    // Scoreboard consumer: every response must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o != 2'b00) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {30'b0, rsp_valid_o}, 64'h0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp", {29'b0, rsp_valid_o, rsp_result_o, rsp_err_o}, {29'b0, e});
                $display("rsp: valid=%b result=%h err=%b", rsp_valid_o, rsp_result_o, rsp_err_o);
            end
        end
    end

    // Caller is positioned 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_op(input int vi);
        vec_t        v;
        logic [2:0]  eop;
        logic [31:0] era, erb, ira, irb;
        logic [7:0]  iop;
        rsp_t        r;
        v = tbl[vi];
        req_valid_i = v.valid;
        req_op_i    = {v.op1, v.op0};
        req_ra_i    = {v.ra1, v.ra0};
        req_rb_i    = {v.rb1, v.rb0};
        #1;
        check("ready", {62'b0, req_ready_o}, v.grant ? 64'd2 : 64'd1);
        r.valid  = v.grant ? 2'b10 : 2'b01;
        r.result = v.res;
        r.err    = v.err;
        sb.push_back(r);
        eop = v.grant ? v.op1 : v.op0;
        era = v.grant ? v.ra1 : v.ra0;
        erb = v.grant ? v.rb1 : v.rb0;
        $display("vec %0d: valid=%b grant=%0d op=%0d ra=%h rb=%h stall=%0d k=%0d",
                 vi, v.valid, v.grant, eop, era, erb, v.stall, v.k);

        @(posedge clk_i); #1;   // ISSUE
        req_op_i = 6'($urandom);
        req_ra_i = {$urandom, $urandom};
        req_rb_i = {$urandom, $urandom};
        check("issue", {23'b0, mdu_valid_o, mdu_op_o, mdu_ra_o},
              {23'b0, 1'b1, 8'h01 << eop, era});
        check("issue_rb", {32'b0, mdu_rb_o}, {32'b0, erb});
        iop = mdu_op_o; ira = mdu_ra_o; irb = mdu_rb_o;
        mdu_stall_i = (v.stall > 0);
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk_i); #1;
            if (s == v.stall - 1) mdu_stall_i = 1'b0;
            check("stall_hold", {mdu_valid_o, mdu_op_o, mdu_ra_o, mdu_rb_o},
                  {1'b1, iop, ira, irb});
        end

        @(posedge clk_i); #1;   // WAIT cycle 0
        check("wait_entry", {61'b0, mdu_valid_o, busy_o, |rsp_valid_o}, 64'b010);
        for (int i = 0; i < TO; i++) begin
            if (i == v.k) begin
                mdu_ready_i  = 1'b1;
                mdu_result_i = mdu_model(iop, ira, irb);
            end
            @(posedge clk_i); #1;
            mdu_ready_i  = 1'b0;
            mdu_result_i = $urandom;
            if (i == v.k || i == TO - 1) break;
            check("wait_hold", {62'b0, busy_o, |rsp_valid_o}, 64'b10);
        end
        check("resp_timing", {62'b0, rsp_valid_o}, {62'b0, r.valid});
        @(posedge clk_i); #1;   // back in IDLE
        check("back_idle", {62'b0, busy_o, |rsp_valid_o}, 64'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          valid  op0   op1   ra0           rb0           ra1           rb1           st k   g     res           err
        tbl[0]  = '{2'b01, 3'd0, 3'd0, 32'd3,        32'd5,        32'd0,        32'd0,        0, 2,  1'b0, 32'd15,       1'b0};
        tbl[1]  = '{2'b11, 3'd0, 3'd5, 32'd1,        32'd1,        32'd100,      32'd7,        3, 0,  1'b1, 32'd14,       1'b0};
        tbl[2]  = '{2'b11, 3'd1, 3'd0, 32'h80000000, 32'd2,        32'd9,        32'd9,        0, 1,  1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[3]  = '{2'b10, 3'd0, 3'd6, 32'd0,        32'd0,        32'hFFFFFFF9, 32'd2,        0, 3,  1'b1, 32'hFFFFFFFF, 1'b0};
        tbl[4]  = '{2'b01, 3'd4, 3'd0, 32'd20,       32'd0,        32'd0,        32'd0,        0, -1, 1'b0, 32'd0,        1'b1};
        tbl[5]  = '{2'b11, 3'd0, 3'd3, 32'd4,        32'd4,        32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0,  1'b1, 32'hFFFFFFFE, 1'b0};
        tbl[6]  = '{2'b11, 3'd7, 3'd0, 32'd10,       32'd3,        32'd2,        32'd2,        0, 2,  1'b0, 32'd1,        1'b0};
        tbl[7]  = '{2'b01, 3'd2, 3'd0, 32'hFFFFFFFF, 32'd2,        32'd0,        32'd0,        0, 1,  1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[8]  = '{2'b11, 3'd0, 3'd0, 32'd6,        32'd7,        32'd1,        32'd1,        0, 0,  1'b0, 32'd42,       1'b0};
        tbl[9]  = '{2'b11, 3'd0, 3'd5, 32'd1,        32'd1,        32'd9,        32'd3,        0, 1,  1'b1, 32'd3,        1'b0};
        tbl[10] = '{2'b11, 3'd7, 3'd0, 32'd17,       32'd5,        32'd1,        32'd1,        0, 0,  1'b0, 32'd2,        1'b0};

        rst_i = 1'b1;
        req_valid_i = 2'b01; req_op_i = '0; req_ra_i = '0; req_rb_i = '0;
        mdu_stall_i = 1'b0; mdu_ready_i = 1'b0; mdu_result_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs",
              {req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o, mdu_valid_o, mdu_op_o, busy_o},
              64'h0);
        check("reset_operands", {mdu_ra_o, mdu_rb_o}, 64'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        req_valid_i = 2'b00;

        for (int i = 0; i < 8; i++) run_op(i);

        // Reset mid-WAIT: the in-flight op must vanish without a response.
        req_valid_i = 2'b10; req_op_i = 6'b000_000; req_ra_i = {32'd2, 32'd0}; req_rb_i = {32'd2, 32'd0};
        @(posedge clk_i); #1;   // ISSUE
        req_valid_i = 2'b00;
        @(posedge clk_i); #1;   // WAIT 0
        @(posedge clk_i); #1;   // WAIT 1
        check("pre_reset_busy", {63'b0, busy_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        check("reset_async", {60'b0, busy_o, mdu_valid_o, rsp_valid_o}, 64'h0);
        req_valid_i = 2'b11;
        #1;
        check("reset_ready_mask", {62'b0, req_ready_o}, 64'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        req_valid_i = 2'b00;
        mdu_ready_i = 1'b1; mdu_result_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        mdu_ready_i = 1'b0;
        check("spurious_ready", {60'b0, busy_o, mdu_valid_o, rsp_valid_o}, 64'h0);
        repeat (6) @(posedge clk_i);
        #1;
        check("idle_after_reset", {63'b0, busy_o}, 64'h0);

        for (int i = 8; i < 11; i++) run_op(i);
        req_valid_i = 2'b00;

        repeat (3) @(posedge clk_i);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of WAIT cycles allowed before an error response.
REQ-002 The block SHALL have port clk_i, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid_i, input, 2: per-requester op request.
REQ-005 The block SHALL have port req_op_i, input, 6: per-requester funct3, 3 bits each; requester n uses [3n+2:3n].
REQ-006 The block SHALL have ports req_ra_i and req_rb_i, input, 64 each: per-requester operands, 32 bits each; requester n uses [32n+31:32n].
REQ-007 The block SHALL have port req_ready_o, output, 2: per-requester accept; a request is taken when valid and ready are both high.
REQ-008 The block SHALL have port rsp_valid_o, output, 2: one-cycle result strobe per requester.
REQ-009 The block SHALL have port rsp_result_o, output, 32: shared result bus, valid only with an rsp_valid_o bit.
REQ-010 The block SHALL have port rsp_err_o, output, 1: timeout flag qualifying rsp_valid_o.
REQ-011 The block SHALL have port mdu_valid_o, output, 1: issue strobe to the mul/div unit.
REQ-012 The block SHALL have port mdu_op_o, output, 8: one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}, bit index equal to funct3.
REQ-013 The block SHALL have ports mdu_ra_o and mdu_rb_o, output, 32 each: operands to the unit.
REQ-014 The block SHALL have port mdu_stall_i, input, 1: the unit cannot accept an issue this cycle.
REQ-015 The block SHALL have ports mdu_ready_i, input, 1, and mdu_result_i, input, 32: one-cycle result strobe and its data.
REQ-016 The block SHALL have port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT and RESP, with one op in flight at most.
REQ-018 In IDLE, when any req_valid_i bit is high, exactly one req_ready_o bit SHALL be high (combinationally); all other req_ready_o bits SHALL be 0.
- If both requesters are valid, grant the one not equal to last_grant.
- Otherwise, grant the sole valid requester.
REQ-019 On accept, the block SHALL latch the grant index, op and operands, and go to ISSUE.
REQ-020 In ISSUE, the block SHALL drive mdu_valid_o=1, decoded mdu_op_o and the latched operands.
- mdu_stall_i=1: stay in ISSUE with outputs held stable.
- mdu_stall_i=0: issue completes; go to WAIT with the timeout counter cleared to 0.
REQ-021 In WAIT, mdu_valid_o SHALL be 0, mdu_op_o and operands SHALL stay stable, and the counter SHALL increment each cycle.
- mdu_ready_i=1: capture mdu_result_i, err=0, go to RESP.
- Counter == TIMEOUT_CYCLES-1 with no ready: result=0, err=1, go to RESP.
- If ready and the terminal count occur in the same cycle, ready SHALL win.
REQ-022 In RESP, for exactly one cycle, the block SHALL drive:
- rsp_valid_o[grant]=1;
- rsp_result_o = the captured value;
- rsp_err_o = err;
- last_grant updated to grant;
- next state IDLE. No request is accepted in RESP.
REQ-023 Outside RESP, rsp_valid_o, rsp_result_o and rsp_err_o SHALL be 0.
REQ-024 Outside ISSUE, mdu_valid_o SHALL be 0 and mdu_op_o SHALL be 0.
REQ-025 The block SHALL ignore mdu_ready_i outside WAIT, with no state change.
REQ-026 Latency SHALL be: accept at cycle T, ISSUE at T+1, WAIT from T+2 with no stall, ready at T+2+k, RESP at T+3+k.
REQ-027 The block SHALL not sample req_* outside the IDLE accept cycle; requesters may change their inputs freely after accept.

Reset
REQ-028 Asserting rst_i SHALL, at any time including mid-operation, immediately force:
- state IDLE;
- counter 0;
- last_grant=1, so requester 0 wins the first tie;
- all latched op and operand registers 0;
- all outputs 0.
An in-flight op is dropped without a response.
REQ-029 After rst_i deasserts, the block SHALL accept a request on the first rising edge at which req_valid_i is high.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold:
- the funct3 op enum (MUL=0 .. REMU=7);
- the FSM state enum;
- the MDU_OP_W=8 constant.
REQ-031 The 2-way round-robin grant logic SHALL be one sub-module, muldiv_rr_arb, with inputs valid[1:0] and last_grant, and outputs grant_valid and grant_idx; all other logic SHALL live in muldiv_arbiter.

Verification
REQ-032 Single op: req0 MUL with ra=3, rb=5; unit gives ready 2 cycles after issue with result 15 -> rsp_valid_o=01, rsp_result_o=15, rsp_err_o=0 at T+5.
REQ-033 Tie after reset: both valid -> req0 granted first. Hold both valid -> req1 granted next, then req0 again (strict alternation).
REQ-034 Stall: mdu_stall_i=1 for 3 cycles in ISSUE -> mdu_valid_o stays 1 with mdu_op_o and operands unchanged; WAIT is entered the cycle after stall drops.
REQ-035 Timeout: TIMEOUT_CYCLES=4, no mdu_ready_i -> RESP after 4 WAIT cycles with rsp_err_o=1 and rsp_result_o=0. Repeat with ready on the terminal cycle -> err=0 and the unit's result returned.
REQ-036 Reset mid-WAIT: assert rst_i -> busy_o=0 and mdu_valid_o=0 immediately; no rsp_valid_o ever follows. A spurious mdu_ready_i in IDLE is ignored.
